// File: rtl/div_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// div_arbiter_pkg
// Shared types and constants for the divider arbiter slice.
//   state_t          : sequencer states (RESPOND used only with DIV_ZERO_CHECK_EN)
//   N_REQ_DEFAULT    : default number of requesters
//   W_DEFAULT        : default operand / result width
//   MAX_REQ          : largest supported requester count
//   index_to_onehot  : requester index -> one-hot grant vector (MAX_REQ wide)
// ---------------------------------------------------------------------------
package div_arbiter_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int W_DEFAULT     = 16;
  localparam int MAX_REQ       = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    WAIT_RELEASE,
    RESPOND
  } state_t;

  function automatic logic [MAX_REQ-1:0] index_to_onehot(input logic [2:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: finds the first set bit of req starting
// at ptr and wrapping around.
//   req   in  N_REQ           request levels
//   ptr   in  $clog2(N_REQ)   search start position
//   found out 1               any request present
//   index out $clog2(N_REQ)   selected requester (0 when found is low)
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] index
);

  localparam int PW = $clog2(N_REQ);

  always_comb begin
    logic [PW:0]   sum;
    logic [PW-1:0] cidx;
    // NOTE: combinational outputs get a default before any branch so no path
    // leaves them unassigned (which would infer a latch); blocking '=' here.
    found = 1'b0;
    index = '0;
    sum   = '0;
    cidx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr + k modulo N_REQ; one extra bit holds the unwrapped sum
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      cidx = sum[PW-1:0];
      if (!found && req[cidx]) begin
        found = 1'b1;
        index = cidx;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
// Round-robin arbiter/sequencer sharing one iterative divider among N_REQ
// requesters. Latches the granted operands, pulses div_comenzar, waits for
// div_finalizado, returns the quotient, then waits for the finish flag to
// drop before the next issue.
//
// Optional feature macro: DIV_ZERO_CHECK_EN
//   defined   : zero divisors bypass the divider (RESPOND state), result is
//               all-ones and req_error pulses with req_done.
//   undefined : zero divisors go to the divider; req_error tied to 0.
//
// Ports
//   clock           in   system clock
//   rst             in   asynchronous active-high reset
//   req_valid       in   N_REQ    request levels, held until req_done
//   req_dividendo   in   N_REQ*W  packed dividends, slice i = [i*W +: W]
//   req_divisor     in   N_REQ*W  packed divisors
//   req_done        out  N_REQ    one-hot completion pulse
//   req_error       out  N_REQ    divide-by-zero flag, with req_done
//   resultado       out  W        quotient, held until next req_done
//   busy            out  1        high whenever not IDLE
//   div_comenzar    out  1        divider start pulse
//   div_dividendo   out  W        divider operand
//   div_divisor     out  W        divider operand
//   div_finalizado  in   1        divider finish level
//   div_cociente    in   32       divider result, [W-1:0] used
// ---------------------------------------------------------------------------
module div_arbiter
  import div_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int W     = W_DEFAULT
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_dividendo,
  input  logic [N_REQ*W-1:0] req_divisor,
  output logic [N_REQ-1:0]   req_done,
  output logic [N_REQ-1:0]   req_error,
  output logic [W-1:0]       resultado,
  output logic               busy,
  output logic               div_comenzar,
  output logic [W-1:0]       div_dividendo,
  output logic [W-1:0]       div_divisor,
  input  logic               div_finalizado,
  input  logic [31:0]        div_cociente
);

  localparam int PW = $clog2(N_REQ);

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      grant_q, grant_d;
  logic [N_REQ-1:0]   req_done_q, req_done_d;
  logic [W-1:0]       resultado_q, resultado_d;
  logic               busy_q, busy_d;
  logic               div_comenzar_q, div_comenzar_d;
  logic [W-1:0]       div_dividendo_q, div_dividendo_d;
  logic [W-1:0]       div_divisor_q, div_divisor_d;
`ifdef DIV_ZERO_CHECK_EN
  logic [N_REQ-1:0]   req_error_q, req_error_d;
`endif

  logic               pick_found;
  logic [PW-1:0]      pick_idx;
  logic [W-1:0]       pick_dividendo;
  logic [W-1:0]       pick_divisor;

  // Upper quotient bits are never returned.
  logic unused_cociente_hi;
  assign unused_cociente_hi = ^div_cociente[31:W];

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req   (req_valid),
    .ptr   (ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  assign pick_dividendo = req_dividendo[pick_idx*W +: W];
  assign pick_divisor   = req_divisor[pick_idx*W +: W];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (i == PW'(N_REQ-1)) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    grant_d         = grant_q;
    req_done_d      = '0;
    resultado_d     = resultado_q;
    div_comenzar_d  = 1'b0;
    div_dividendo_d = div_dividendo_q;
    div_divisor_d   = div_divisor_q;
`ifdef DIV_ZERO_CHECK_EN
    req_error_d     = '0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d         = pick_idx;
          div_dividendo_d = pick_dividendo;
          div_divisor_d   = pick_divisor;
`ifdef DIV_ZERO_CHECK_EN
          if (pick_divisor == '0) begin
            // Answer directly; the divider is never started.
            state_d     = RESPOND;
            resultado_d = '1;
            req_done_d  = N_REQ'(index_to_onehot(3'(pick_idx)));
            req_error_d = N_REQ'(index_to_onehot(3'(pick_idx)));
            ptr_d       = next_ptr(pick_idx);
          end else begin
            state_d        = ISSUE;
            div_comenzar_d = 1'b1;
          end
`else
          state_d        = ISSUE;
          div_comenzar_d = 1'b1;
`endif
        end
      end
      // div_comenzar_q is high for the whole ISSUE cycle.
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (div_finalizado) begin
          state_d     = WAIT_RELEASE;
          resultado_d = div_cociente[W-1:0];
          req_done_d  = N_REQ'(index_to_onehot(3'(grant_q)));
          ptr_d       = next_ptr(grant_q);
        end
      end
      // The finish flag is a level; issuing before it drops could let the
      // stale flag be mistaken for completion of the next operation.
      WAIT_RELEASE: begin
        if (!div_finalizado) state_d = IDLE;
      end
`ifdef DIV_ZERO_CHECK_EN
      RESPOND: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: every flop here, operands included, is reset so the divider port
  // and all outputs read 0 immediately on rst, even mid-operation.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      ptr_q           <= '0;
      grant_q         <= '0;
      req_done_q      <= '0;
      resultado_q     <= '0;
      busy_q          <= 1'b0;
      div_comenzar_q  <= 1'b0;
      div_dividendo_q <= '0;
      div_divisor_q   <= '0;
`ifdef DIV_ZERO_CHECK_EN
      req_error_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking '<=' so every flop samples pre-edge values.
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      grant_q         <= grant_d;
      req_done_q      <= req_done_d;
      resultado_q     <= resultado_d;
      busy_q          <= busy_d;
      div_comenzar_q  <= div_comenzar_d;
      div_dividendo_q <= div_dividendo_d;
      div_divisor_q   <= div_divisor_d;
`ifdef DIV_ZERO_CHECK_EN
      req_error_q     <= req_error_d;
`endif
    end
  end

  assign req_done      = req_done_q;
  assign resultado     = resultado_q;
  assign busy          = busy_q;
  assign div_comenzar  = div_comenzar_q;
  assign div_dividendo = div_dividendo_q;
  assign div_divisor   = div_divisor_q;
`ifdef DIV_ZERO_CHECK_EN
  assign req_error     = req_error_q;
`else
  assign req_error     = '0;
`endif

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares the single iterative 16-bit divider among up to N_REQ calculator requesters. It latches one request's operands and pulses the divider's start input. It then waits for the divider's finish flag, returns the quotient to the granted requester, and blocks the next issue until the divider is back in its idle state.

## Interface
- N_REQ, 4: number of requesters (2..8).
- W, 16: operand and result width.
- clock  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  N_REQ  per-requester request level; held until matching req_done.
- req_dividendo  in  N_REQ*W  packed dividends; slice i = [i*W +: W].
- req_divisor  in  N_REQ*W  packed divisors.
- req_done  out  N_REQ  one-cycle completion pulse, one-hot.
- req_error  out  N_REQ  one-cycle divide-by-zero flag, coincident with req_done.
- resultado  out  W  quotient, valid in the req_done cycle and held until the next req_done.
- busy  out  1  high in every state except IDLE.
- div_comenzar  out  1  divider start pulse.
- div_dividendo  out  W  operand to divider.
- div_divisor  out  W  operand to divider.
- div_finalizado  in  1  divider finish level; stays high for several cycles.
- div_cociente  in  32  divider result; only [W-1:0] is used.

## Operation
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; grant index 0.
- IDLE: if any req_valid is high, pick the first set bit searching from the pointer upward, with wrap. Latch the grant index, div_dividendo, and div_divisor. Go to ISSUE.
- ISSUE: div_comenzar=1 for exactly this cycle. Go to WAIT_DONE.
- WAIT_DONE: hold operands stable. On the first cycle div_finalizado=1:
  - resultado <= div_cociente[W-1:0];
  - req_done[g] <= 1 for one cycle;
  - pointer <= g+1 mod N_REQ;
  - go to WAIT_RELEASE.
- WAIT_RELEASE: stay until div_finalizado=0, then go to IDLE. No issue is possible while the finish flag is high.
- Operands on div_* stay constant from IDLE exit until WAIT_RELEASE exit.
- A requester dropping req_valid after grant has no effect: the operation completes and req_done is still pulsed.
- A requester must see req_done before starting a new request. req_valid still high in the cycle after req_done is treated as a new request.
- Reset mid-operation returns the arbiter to reset values immediately; no req_done is issued. The divider shares rst.

## Timing
- Request to divider start: 2 cycles (IDLE latch, then div_comenzar in ISSUE).
- req_done is registered: asserted 1 cycle after div_finalizado is first sampled high.
- Total latency = 3 + divider latency, plus any wait behind other requesters.
- Minimum spacing between two grants = divider busy time + finish-flag hold time + 2 cycles.
- Worst-case wait for requester i is N_REQ−1 full operations.

## Configuration
- DIV_ZERO_CHECK_EN defined:
  - In IDLE, a granted divisor of 0 bypasses the divider: state goes to RESPOND (one cycle).
  - RESPOND: resultado=all-ones, req_done[g]=1 and req_error[g]=1, pointer advances.
  - Next state IDLE; latency 2 cycles; div_comenzar never asserted.
- DIV_ZERO_CHECK_EN undefined:
  - A zero divisor is forwarded to the divider and its quotient is returned.
  - req_error is tied to 0 and the RESPOND state is absent.

## Structure
- Package div_arbiter_pkg holds:
  - state enum IDLE/ISSUE/WAIT_DONE/WAIT_RELEASE/RESPOND;
  - default constants N_REQ=4, W=16;
  - function index_to_onehot.
- Sub-module rr_picker: combinational search of req_valid from the pointer, with wrap. Outputs found and index.

## Test plan
- Single request: requester 0 divides 100 by 7. Require:
  - div_comenzar is one pulse;
  - resultado=14 with req_done=4'b0001;
  - busy=0 after div_finalizado falls.
- Simultaneous requests: requesters 0 and 2 assert in the same cycle with 200/10 and 81/9. Require:
  - requester 0 is served first with result 20;
  - then requester 2 with result 9;
  - pointer=3.
- Fairness: all four hold req_valid continuously. Require grant order 0,1,2,3,0 and no starvation.
- Release guard: requester 1 reasserts right after req_done. Require no div_comenzar while div_finalizado=1; the next issue comes only after it falls.
- Divide-by-zero with DIV_ZERO_CHECK_EN: requester 3 divides 55 by 0. Require:
  - resultado=16'hFFFF;
  - req_done[3] and req_error[3] both pulse;
  - no div_comenzar.
- Reset during WAIT_DONE: require outputs cleared within the same cycle, no req_done, and a clean restart of 9/3 → 3.
